// File: rtl/shift_add_muladd.sv
// shift_add_muladd: sequential shift-and-add multiply-accumulate, p = a*b + c, unsigned.
// Processes one multiplier bit per clock. Feeding (divisor, quotient, remainder) from the
// restoring divider reconstructs the dividend.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous reset, active-low
//   i_start  request, sampled only in idle
//   i_a      multiplicand (WIDTH)
//   i_b      multiplier (WIDTH)
//   i_c      addend, zero-extended (WIDTH)
//   o_busy   high while running and in the done cycle
//   o_done   one-cycle pulse, o_p valid in that cycle
//   o_p      result (2*WIDTH), held until the next accepted start
//
// Configuration: define EARLY_TERM_EN to finish as soon as no set multiplier bits remain.
// Without it, every operation takes WIDTH cycles from accept to done.

module shift_add_muladd #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_c,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_p
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]     r_b_sh;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_p;

  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   w_a_sh_nxt;
  logic [WIDTH-1:0]     w_b_sh_nxt;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [2*WIDTH-1:0]   w_p_nxt;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic                 w_last;

  // Accumulator after this edge's partial product; the carry out is provably zero.
  assign w_acc_step = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

`ifdef EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_LAST) || ((r_b_sh >> 1) == '0);
`else
  assign w_last = (r_cnt == CNT_LAST);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_a_sh_nxt  = r_a_sh;
    w_b_sh_nxt  = r_b_sh;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_p_nxt     = r_p;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_a_sh_nxt  = {{WIDTH{1'b0}}, i_a};
          w_b_sh_nxt  = i_b;
          w_acc_nxt   = {{WIDTH{1'b0}}, i_c};
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_acc_nxt  = w_acc_step;
        w_a_sh_nxt = r_a_sh << 1;
        w_b_sh_nxt = r_b_sh >> 1;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_p_nxt     = w_acc_step;
          w_done_nxt  = 1'b1;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = StIdle;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a_sh  <= w_a_sh_nxt;
      r_b_sh  <= w_b_sh_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_p     <= w_p_nxt;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_p    = r_p;

endmodule

// File: tb/tb_shift_add_muladd.sv
// Testbench for shift_add_muladd: random and directed operations checked against a
// plain-arithmetic reference (p = a*b + c, latency from the multiplier's bit length).

module tb_shift_add_muladd;

  localparam int unsigned W = 4;
  localparam int LIMIT = 3 * W + 4;

  logic           i_clk;
  logic           i_rst_n;
  logic           i_start;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic [W-1:0]   i_c;
  logic           o_busy;
  logic           o_done;
  logic [2*W-1:0] o_p;

  int n_checks;
  int n_fail;

  shift_add_muladd #(.WIDTH(W)) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_p     (o_p)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cycles from the accept edge to done, from the multiplier's bit length.
  function automatic int exp_lat(input int b);
`ifdef EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < int'(W); i++) if ((b >> i) & 1) n = i + 1;
    return n;
`else
    return int'(W);
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // Operands are scrambled after accept; with noise, start is also toggled while busy.
  task automatic do_op(input int a, input int b, input int c, input bit noise);
    int k;
    bit seen;
    logic [31:0] exp_p;
    exp_p = a * b + c;
    i_a = W'(a);
    i_b = W'(b);
    i_c = W'(c);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check_eq("busy_after_accept", {31'd0, o_busy}, 1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < LIMIT) begin
      i_a = W'($urandom);
      i_b = W'($urandom);
      i_c = W'($urandom);
      if (noise) i_start = 1'($urandom);
      @(negedge i_clk);
      k++;
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0;
    check_eq("done_seen", {31'd0, seen}, 1);
    if (!seen) return;
    check_eq("p", {24'd0, o_p}, exp_p);
    check_eq("latency", k, exp_lat(b));
    check_eq("busy_at_done", {31'd0, o_busy}, 1);
    @(negedge i_clk);
    check_eq("done_pulse", {31'd0, o_done}, 0);
    check_eq("busy_idle", {31'd0, o_busy}, 0);
    check_eq("p_hold", {24'd0, o_p}, exp_p);
  endtask

  initial begin
    int extra;
    n_checks = 0;
    n_fail   = 0;
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    i_a      = '0;
    i_b      = '0;
    i_c      = '0;
    repeat (2) @(negedge i_clk);
    check_eq("rst_busy", {31'd0, o_busy}, 0);
    check_eq("rst_done", {31'd0, o_done}, 0);
    check_eq("rst_p", {24'd0, o_p}, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Directed cases.
    do_op(13, 11, 7, 1'b0);
    do_op(15, 15, 15, 1'b0);
    do_op(9, 0, 5, 1'b0);
    do_op(0, 9, 3, 1'b0);
    do_op(1, 4, 0, 1'b0);

    // Start two cycles into an operation must be ignored; done exactly once.
    i_a = 4'd3; i_b = 4'd2; i_c = 4'd0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    i_a = 4'd7; i_b = 4'd7; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    extra = 0;
    for (int i = 0; i < LIMIT; i++) begin
      if (o_done) begin
        extra++;
        check_eq("ignored_start_p", {24'd0, o_p}, 6);
      end
      @(negedge i_clk);
    end
    check_eq("done_count", extra, 1);
    check_eq("ignored_start_idle", {31'd0, o_busy}, 0);

    // Reset mid-operation.
    i_a = 4'd5; i_b = 4'd5; i_c = 4'd1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, o_busy}, 0);
    check_eq("midrst_done", {31'd0, o_done}, 0);
    check_eq("midrst_p", {24'd0, o_p}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check_eq("post_rst_idle", {31'd0, o_busy}, 0);
    do_op(5, 5, 1, 1'b0);

    // Full operand sweep with random start noise while busy.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++)
          do_op(a, b, c, 1'($urandom));

    // Divider inverse: (D, N/D, N%D) rebuilds N.
    for (int n = 0; n < 16; n++)
      for (int d = 1; d < 16; d++)
        do_op(d, n / d, n % d, 1'b0);

    // Random operations.
    for (int i = 0; i < 200; i++)
      do_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
            1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
